// File: rtl/qram_cell_sequencer.sv
// Host read/write sequencer for one bit-plane of dynamic QRAM cells, with a
// periodic round-robin refresh (read then write-back) of every cell.
//
// state     | meaning
// IDLE      | waiting; services pending refresh before host requests
// LOAD      | host write: load strobe on addressed cell, CellIn = write bit
// DRIVE     | host read: drive strobe on addressed cell, sample at end
// RESP      | one-cycle completion pulse
// REF_DRIVE | refresh read of cell at refresh pointer
// REF_LOAD  | refresh write-back of the captured bit
module qram_cell_sequencer #(
    parameter int DEPTH          = 8,
    parameter int ADDR_W         = 3,
    parameter int LOAD_CYCLES    = 2,
    parameter int SETTLE_CYCLES  = 2,
    parameter int REFRESH_PERIOD = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic              req_data_i,
    output logic              resp_valid_o,
    output logic              resp_write_o,
    output logic              resp_data_o,
    output logic [DEPTH-1:0]  cell_load_o,
    output logic              cell_in_o,
    output logic [DEPTH-1:0]  cell_drive_o,
    input  logic [DEPTH-1:0]  cell_out_i
);

    localparam int TMR_MAX = (LOAD_CYCLES > SETTLE_CYCLES) ? LOAD_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int CNT_W   = $clog2(REFRESH_PERIOD);

    typedef enum logic [2:0] {
        IDLE, LOAD, DRIVE, RESP, REF_DRIVE, REF_LOAD
    } state_t;

    state_t             state_q;
    logic [TMR_W-1:0]   tmr_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               expire;
    logic               pending_q;
    logic [ADDR_W-1:0]  ptr_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               req_ready_q, resp_valid_q, resp_write_q, resp_data_q;
    logic [DEPTH-1:0]   load_q, drive_q;
    logic               in_q;
    logic               rd_bit, ref_bit;

    // Out-of-range addresses decode to all-zero, so they strobe nothing and read 0.
    function automatic logic [DEPTH-1:0] onehot(input logic [ADDR_W-1:0] a);
        logic [DEPTH-1:0] v;
        v = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (a == ADDR_W'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

    always_comb begin
        expire  = (cnt_q == CNT_W'(REFRESH_PERIOD - 1));
        cnt_d   = expire ? '0 : cnt_q + 1'b1;
        rd_bit  = |(cell_out_i & onehot(addr_q));
        ref_bit = |(cell_out_i & onehot(ptr_q));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            tmr_q        <= '0;
            cnt_q        <= '0;
            pending_q    <= 1'b0;
            ptr_q        <= '0;
            addr_q       <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_write_q <= 1'b0;
            resp_data_q  <= 1'b0;
            load_q       <= '0;
            drive_q      <= '0;
            in_q         <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            resp_valid_q <= 1'b0;
            if (expire) pending_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (pending_q) begin
                        state_q     <= REF_DRIVE;
                        pending_q   <= expire;
                        tmr_q       <= TMR_W'(SETTLE_CYCLES - 1);
                        drive_q     <= onehot(ptr_q);
                        req_ready_q <= 1'b0;
                    end else if (req_valid_i && req_ready_q) begin
                        addr_q      <= req_addr_i;
                        req_ready_q <= 1'b0;
                        if (req_write_i) begin
                            state_q <= LOAD;
                            tmr_q   <= TMR_W'(LOAD_CYCLES - 1);
                            load_q  <= onehot(req_addr_i);
                            in_q    <= req_data_i;
                        end else begin
                            state_q <= DRIVE;
                            tmr_q   <= TMR_W'(SETTLE_CYCLES - 1);
                            drive_q <= onehot(req_addr_i);
                        end
                    end else begin
                        req_ready_q <= !expire;
                    end
                end
                LOAD: begin
                    if (tmr_q == '0) begin
                        state_q      <= RESP;
                        load_q       <= '0;
                        in_q         <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_write_q <= 1'b1;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                DRIVE: begin
                    if (tmr_q == '0) begin
                        state_q      <= RESP;
                        drive_q      <= '0;
                        resp_valid_q <= 1'b1;
                        resp_write_q <= 1'b0;
                        resp_data_q  <= rd_bit;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    req_ready_q <= !(pending_q || expire);
                end
                REF_DRIVE: begin
                    if (tmr_q == '0) begin
                        state_q <= REF_LOAD;
                        tmr_q   <= TMR_W'(LOAD_CYCLES - 1);
                        drive_q <= '0;
                        load_q  <= onehot(ptr_q);
                        in_q    <= ref_bit;
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                REF_LOAD: begin
                    if (tmr_q == '0) begin
                        state_q     <= IDLE;
                        load_q      <= '0;
                        in_q        <= 1'b0;
                        ptr_q       <= (ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
                        req_ready_q <= !(pending_q || expire);
                    end else begin
                        tmr_q <= tmr_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    load_q  <= '0;
                    drive_q <= '0;
                    in_q    <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o  = req_ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_write_o = resp_write_q;
    assign resp_data_o  = resp_data_q;
    assign cell_load_o  = load_q;
    assign cell_drive_o = drive_q;
    assign cell_in_o    = in_q;

endmodule

// File: tb/tb_qram_cell_sequencer.sv
// Bench for qram_cell_sequencer: directed timing/refresh/reset steps, then
// random traffic against a cell-array model and a response scoreboard.
module tb_qram_cell_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_write = 1'b0;
    logic [2:0] req_addr = '0;
    logic       req_data = 1'b0;
    logic       resp_valid, resp_write, resp_data;
    logic [7:0] cell_load, cell_drive;
    logic       cell_in;
    logic [7:0] mem = 8'h01;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;
    bit mon_en  = 1'b0;

    typedef struct packed {
        logic wr;
        logic data;
    } exp_t;
    exp_t sb_q[$];
    exp_t sb_e;
    logic [7:0] last_wr = '0;

    qram_cell_sequencer dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_write_i  (req_write),
        .req_addr_i   (req_addr),
        .req_data_i   (req_data),
        .resp_valid_o (resp_valid),
        .resp_write_o (resp_write),
        .resp_data_o  (resp_data),
        .cell_load_o  (cell_load),
        .cell_in_o    (cell_in),
        .cell_drive_o (cell_drive),
        .cell_out_i   (mem)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) edge_n <= 0;
        else     edge_n <= edge_n + 1;
        for (int i = 0; i < 8; i++) begin
            if (cell_load[i] === 1'b1) mem[i] <= cell_in;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("load_onehot0", 32'($onehot0(cell_load)), 1);
            check("drive_onehot0", 32'($onehot0(cell_drive)), 1);
            check("load_and_drive", 32'((|cell_load) && (|cell_drive)), 0);
            if (resp_valid === 1'b1) begin
                check("resp_expected", 32'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    sb_e = sb_q.pop_front();
                    check("resp_write", resp_write, sb_e.wr);
                    if (!sb_e.wr) check("resp_data", resp_data, sb_e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_edge(input int n);
        while (edge_n < n) step();
    endtask

    task automatic push_exp(input logic wr, input logic [2:0] a, input logic d);
        exp_t e;
        e.wr   = wr;
        e.data = wr ? 1'b0 : last_wr[a];
        sb_q.push_back(e);
        if (wr) last_wr[a] = d;
    endtask

    task automatic drive_req(input logic wr, input logic [2:0] a, input logic d);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_data  = d;
    endtask

    task automatic scramble_req();
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = 3'($urandom);
        req_data  = 1'($urandom);
    endtask

    task automatic do_req(input logic wr, input logic [2:0] a, input logic d);
        bit acc;
        acc = 1'b0;
        drive_req(wr, a, d);
        for (int i = 0; i < 200 && !acc; i++) begin
            if (req_ready === 1'b1) begin
                acc = 1'b1;
                push_exp(wr, a, d);
            end
            step();
        end
        scramble_req();
        check("req_accepted", 32'(acc), 1);
    endtask

    initial begin
        // Reset state
        step();
        step();
        check("rst_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_load", cell_load, 0);
        check("rst_drive", cell_drive, 0);
        check("rst_cell_in", cell_in, 0);
        mon_en = 1'b1;
        rst = 1'b0;
        goto_edge(1);
        check("ready_after_rst", req_ready, 1);

        // First refresh: cell 0 holding 1
        goto_edge(64);
        check("pending_ready", req_ready, 0);
        goto_edge(65);
        check("ref0_drive_a", cell_drive, 8'h01);
        goto_edge(66);
        check("ref0_drive_b", cell_drive, 8'h01);
        check("ref0_no_load", cell_load, 0);
        goto_edge(67);
        check("ref0_load_a", cell_load, 8'h01);
        check("ref0_in_a", cell_in, 1);
        goto_edge(68);
        check("ref0_load_b", cell_load, 8'h01);
        check("ref0_in_b", cell_in, 1);
        goto_edge(69);
        check("ref0_done_load", cell_load, 0);
        check("ref0_ready", req_ready, 1);

        // Write addr 5 <- 1
        drive_req(1'b1, 3'd5, 1'b1);
        push_exp(1'b1, 3'd5, 1'b1);
        goto_edge(70);
        scramble_req();
        check("wr_load_c1", cell_load, 8'h20);
        check("wr_in_c1", cell_in, 1);
        check("wr_ready_c1", req_ready, 0);
        goto_edge(71);
        check("wr_load_c2", cell_load, 8'h20);
        check("wr_in_c2", cell_in, 1);
        goto_edge(72);
        check("wr_resp_valid", resp_valid, 1);
        check("wr_resp_write", resp_write, 1);
        check("wr_ready_c3", req_ready, 0);
        check("wr_load_c3", cell_load, 0);
        goto_edge(73);
        check("wr_resp_pulse", resp_valid, 0);
        check("wr_ready_c4", req_ready, 1);

        // Read addr 5 -> 1
        drive_req(1'b0, 3'd5, 1'b0);
        push_exp(1'b0, 3'd5, 1'b0);
        goto_edge(74);
        scramble_req();
        check("rd_drive_c1", cell_drive, 8'h20);
        goto_edge(75);
        check("rd_drive_c2", cell_drive, 8'h20);
        goto_edge(76);
        check("rd1_resp_valid", resp_valid, 1);
        check("rd1_resp_data", resp_data, 1);
        check("rd_drive_c3", cell_drive, 0);
        goto_edge(77);
        check("rd1_data_hold", resp_data, 1);

        // Write addr 5 <- 0 then read it back
        drive_req(1'b1, 3'd5, 1'b0);
        push_exp(1'b1, 3'd5, 1'b0);
        goto_edge(78);
        scramble_req();
        goto_edge(80);
        check("wr0_resp_valid", resp_valid, 1);
        check("wr0_data_hold", resp_data, 1);
        goto_edge(81);
        drive_req(1'b0, 3'd5, 1'b1);
        push_exp(1'b0, 3'd5, 1'b0);
        goto_edge(82);
        scramble_req();
        goto_edge(84);
        check("rd0_resp_valid", resp_valid, 1);
        check("rd0_resp_data", resp_data, 0);

        // Second refresh targets cell 1
        goto_edge(129);
        check("ref1_drive", cell_drive, 8'h02);
        goto_edge(131);
        check("ref1_load", cell_load, 8'h02);
        check("ref1_in", cell_in, 0);

        // Ninth refresh wraps back to cell 0 and leaves RespData alone
        goto_edge(577);
        check("ref8_drive", cell_drive, 8'h01);
        goto_edge(579);
        check("ref8_load", cell_load, 8'h01);
        check("ref8_in", cell_in, 1);
        goto_edge(581);
        check("ref_resp_data_kept", resp_data, 0);

        // Request arriving with pending refresh waits for the refresh
        goto_edge(640);
        drive_req(1'b1, 3'd3, 1'b1);
        check("prio_ready", req_ready, 0);
        goto_edge(641);
        check("prio_ref_drive", cell_drive, 8'h02);
        check("prio_not_accepted", cell_load, 0);
        goto_edge(643);
        check("prio_ref_load", cell_load, 8'h02);
        goto_edge(645);
        check("prio_ready_after", req_ready, 1);
        push_exp(1'b1, 3'd3, 1'b1);
        goto_edge(646);
        scramble_req();
        check("prio_wr_load", cell_load, 8'h08);
        check("prio_wr_in", cell_in, 1);
        goto_edge(648);
        check("prio_resp_valid", resp_valid, 1);

        // Reset in the second LOAD cycle of a write
        goto_edge(649);
        drive_req(1'b1, 3'd6, 1'b1);
        goto_edge(650);
        scramble_req();
        check("abort_load_c1", cell_load, 8'h40);
        goto_edge(651);
        check("abort_load_c2", cell_load, 8'h40);
        rst = 1'b1;
        step();
        check("abort_load", cell_load, 0);
        check("abort_drive", cell_drive, 0);
        check("abort_in", cell_in, 0);
        check("abort_ready", req_ready, 0);
        check("abort_no_resp", resp_valid, 0);
        rst = 1'b0;
        step();
        check("abort_ready_after", req_ready, 1);
        check("abort_no_resp_after", resp_valid, 0);
        goto_edge(65);
        check("abort_ptr_zero", cell_drive, 8'h01);
        goto_edge(69);

        // Random traffic: seed every cell, then mixed reads/writes
        for (int a = 0; a < 8; a++) do_req(1'b1, 3'(a), 1'($urandom));
        for (int n = 0; n < 40; n++) begin
            do_req(1'($urandom), 3'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 3)) step();
        end

        for (int i = 0; i < 50 && sb_q.size() > 0; i++) step();
        check("sb_drained", sb_q.size(), 0);
        repeat (4) step();
        check("sb_no_extra", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
